result_queue: RTL and testbench
===============================

RESULT_QUEUE -- requirements
Module: result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter ZERO_BITS, default 32, meaning the number of leading hash bits that must be zero for a share.
REQ-003 SHALL have parameter TAG, default 64'hdead432987beefaa, meaning the message trailer placed in tx_data[511:448].
REQ-004 Ports: clk  in  1  single clock; all logic rising-edge.
REQ-005 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: hash  in  256  double-SHA result from the finisher stage.
REQ-007 Ports: nonce  in  32  nonce paired with hash.
REQ-008 Ports: in_valid  in  1  hash/nonce pair is valid this cycle.
REQ-009 Ports: tx_data  out  512  formatted message to the UART multibyte transmitter.
REQ-010 Ports: tx_valid  out  1  tx_data holds an unsent share.
REQ-011 Ports: tx_ready  in  1  transmitter accepts tx_data this cycle.
REQ-012 Ports: count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 Ports: drop_count  out  16  shares lost to overflow, saturating.

Function
REQ-014 A share is in_valid=1 with hash[255:256-ZERO_BITS] all zero; non-shares SHALL be ignored.
REQ-015 A share SHALL be written at the clk edge ending its cycle if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
REQ-016 Pop SHALL occur exactly on cycles with tx_valid=1 and tx_ready=1.
REQ-017 tx_valid SHALL equal (count!=0), registered; latency from a share cycle into an empty queue to tx_valid=1 SHALL be 1 cycle.
REQ-018 Message layout: tx_data[255:0]=hash, [263:256]=8'haa, [295:264]=nonce, [303:296]=8'haa, [447:304]=0, [511:448]=TAG.
REQ-019 tx_data SHALL always reflect the head entry and SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-020 Order SHALL be FIFO; simultaneous push and pop SHALL leave count unchanged.
REQ-021 A share arriving when full with no pop SHALL be dropped; drop_count SHALL increment, saturating at 16'hffff.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.
REQ-023 tx_ready while tx_valid=0 SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL immediately clear count, both pointers, and drop_count, and drive tx_valid=0, regardless of clock.
REQ-025 Reset mid-transfer SHALL discard all queued shares; FIFO storage contents need not be cleared.
REQ-026 The first edge after rst_n deasserts SHALL accept a share normally.

Configuration
REQ-027 Macro RESULT_QUEUE_DUP_FILTER_EN, when defined, SHALL drop any share whose nonce equals the most recently accepted nonce (register cleared by reset, with its valid flag 0), without incrementing drop_count.
REQ-028 Without RESULT_QUEUE_DUP_FILTER_EN every share SHALL be queued per REQ-015.

Structure
REQ-029 A shared package SHALL hold the 8'haa separator constant, the default TAG, and the message field offsets, for reuse by the receiver-side parser.
REQ-030 FIFO storage and pointers SHALL be one sub-module, result_fifo; share detection, formatting, and counters stay in result_queue.

Verification
REQ-031 Share hash=256'h0000_0000_1234..., nonce=32'h5, tx_ready=1 -> tx_valid=1 one cycle later, tx_data[295:264]=32'h5, [511:448]=TAG, then pop.
REQ-032 hash with top word 32'h0000_0001, in_valid=1 -> nothing queued, count stays 0.
REQ-033 Six consecutive shares (nonces 1..6), tx_ready=0, DEPTH=4 -> count=4, drop_count=2; then tx_ready=1 -> output nonces 1,2,3,4 in order.
REQ-034 Full queue, share plus pop in the same cycle -> count stays 4, drop_count unchanged, new nonce is last out.
REQ-035 rst_n pulsed low with 3 queued shares -> tx_valid=0 and count=0 asynchronously; the next share is output after 1 cycle.
REQ-036 With RESULT_QUEUE_DUP_FILTER_EN, nonce 7 presented for 3 cycles -> exactly one entry, drop_count=0.

Source files
------------

// File: rtl/result_queue_pkg.sv
// Shared definitions for the share result queue and the receiver-side parser:
// separator byte, default trailer tag, message field offsets, and helpers.
package result_queue_pkg;

  localparam logic [7:0]  SEP_BYTE    = 8'haa;
  localparam logic [63:0] DEFAULT_TAG = 64'hdead432987beefaa;

  localparam int HASH_LSB  = 0;
  localparam int SEP0_LSB  = 256;
  localparam int NONCE_LSB = 264;
  localparam int SEP1_LSB  = 296;
  localparam int PAD_LSB   = 304;
  localparam int TAG_LSB   = 448;
  localparam int MSG_W     = 512;

  typedef struct packed {
    logic [255:0] hash;
    logic [31:0]  nonce;
  } share_t;

  // True when the top zero_bits bits of the hash are all zero.
  function automatic logic hash_is_share(input logic [255:0] h, input int zero_bits);
    logic [255:0] ones;
    logic [255:0] mask;
    ones = '1;
    mask = ~(ones >> zero_bits);
    return ((h & mask) == '0);
  endfunction

  // Builds the transmit message; bits between the second separator and the tag stay zero.
  function automatic logic [MSG_W-1:0] format_msg(input logic [255:0] h, input logic [31:0] n,
                                                  input logic [63:0] tag);
    logic [MSG_W-1:0] m;
    m = '0;
    m[HASH_LSB  +: 256] = h;
    m[SEP0_LSB  +: 8]   = SEP_BYTE;
    m[NONCE_LSB +: 32]  = n;
    m[SEP1_LSB  +: 8]   = SEP_BYTE;
    m[TAG_LSB   +: 64]  = tag;
    return m;
  endfunction

endpackage

// File: rtl/result_queue_if.sv
// Finisher-side hash/nonce input and transmitter-side message handshake.
interface result_queue_if;
  logic [255:0] hash;
  logic [31:0]  nonce;
  logic         in_valid;
  logic [511:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (output hash, nonce, in_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input hash, nonce, in_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/result_fifo.sv
// Storage and wrapping read/write pointers for queued shares. Occupancy is
// tracked by the caller, which only pushes when there is room.
module result_fifo
  import result_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  share_t wr_entry,
  output share_t rd_entry
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  share_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/result_queue.sv
// Share result queue: filters hash/nonce pairs for shares, buffers them in a
// small FIFO and presents the head as a formatted message to the transmitter.
// Optional build macro RESULT_QUEUE_DUP_FILTER_EN drops a share whose nonce
// repeats the most recently accepted one (not counted as an overflow drop).
module result_queue
  import result_queue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          ZERO_BITS = 32,
  parameter logic [63:0] TAG       = DEFAULT_TAG
) (
  input  logic                   clk,
  input  logic                   rst_n,
  result_queue_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_count
);
  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  logic   tx_valid_q;
  logic   share;
  logic   full;
  logic   pop;
  logic   push;
  logic   drop;
  share_t wr_entry;
  share_t rd_entry;

`ifdef RESULT_QUEUE_DUP_FILTER_EN
  logic [31:0] last_nonce;
  logic        last_valid;

  assign share = bus.in_valid && hash_is_share(bus.hash, ZERO_BITS)
                 && !(last_valid && (bus.nonce == last_nonce));

  // Remember the nonce of the last share actually queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_nonce <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_nonce <= bus.nonce;
      last_valid <= 1'b1;
    end
  end
`else
  assign share = bus.in_valid && hash_is_share(bus.hash, ZERO_BITS);
`endif

  assign full = (count == FULL_COUNT);
  assign pop  = tx_valid_q && bus.tx_ready;
  // A pop in the same cycle frees the slot for a share arriving while full.
  assign push = share && (!full || pop);
  assign drop = share && full && !pop;

  // Occupancy and registered tx_valid move together so tx_valid == (count != 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          count      <= count + CW'(1);
          tx_valid_q <= 1'b1;
        end
        2'b01: begin
          count      <= count - CW'(1);
          tx_valid_q <= (count != CW'(1));
        end
        default: begin
        end
      endcase
    end
  end

  // Overflow drop counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              drop_count <= '0;
    else if (drop && (drop_count != 16'hffff)) drop_count <= drop_count + 16'd1;
  end

  assign wr_entry.hash  = bus.hash;
  assign wr_entry.nonce = bus.nonce;

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry)
  );

  assign bus.tx_data  = format_msg(rd_entry.hash, rd_entry.nonce, TAG);
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_result_queue.sv
module tb_result_queue;
  localparam int          DEPTH = 4;
  localparam logic [63:0] TAG   = 64'hdead432987beefaa;

  logic        clk;
  logic        rst_n;
  logic [2:0]  count;
  logic [15:0] drop_count;

  result_queue_if bus ();

  result_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .count      (count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of expected messages, drop tally, last accepted nonce.
  logic [511:0] mq[$];
  logic [511:0] exp_out[$];
  logic [511:0] obs_out[$];
  int           m_drop = 0;
  logic [31:0]  m_last = '0;
  bit           m_last_valid = 0;

  function automatic logic [511:0] fmt(input logic [255:0] h, input logic [31:0] n);
    return {TAG, 144'h0, 8'haa, n, 8'haa, h};
  endfunction

  function automatic logic [255:0] share_hash(input logic [31:0] low);
    return {32'h0, 192'h1234_5678_9abc_def0_1111_2222_3333_4444_5555_6666_7777_8888, low};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drop = 0;
    m_last_valid = 0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), record DUT pops, step the model.
  task automatic drive_cycle(input logic [255:0] h, input logic [31:0] n,
                             input logic v, input logic rdy);
    bit is_share, is_pop, was_full;
    bus.hash = h; bus.nonce = n; bus.in_valid = v; bus.tx_ready = rdy;
    #1;
    if (bus.tx_valid && rdy) obs_out.push_back(bus.tx_data);
    is_share = v && (h[255:224] == 32'h0);
`ifdef RESULT_QUEUE_DUP_FILTER_EN
    if (m_last_valid && n == m_last) is_share = 0;
`endif
    was_full = (mq.size() == DEPTH);
    is_pop   = (mq.size() != 0) && rdy;
    if (is_pop) exp_out.push_back(mq.pop_front());
    if (is_share) begin
      if (!was_full || is_pop) begin
        mq.push_back(fmt(h, n));
        m_last = n;
        m_last_valid = 1;
      end else if (m_drop < 65535) m_drop++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.tx_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.hash = '0; bus.nonce = '0; bus.in_valid = 0; bus.tx_ready = 0;
    #3;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_single_share();
    exp_out.delete(); obs_out.delete();
    drive_cycle(share_hash(32'hcafe), 32'h5, 1, 1);
    n_checks++;
    if (bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.tx_valid); end
    n_checks++;
    if (bus.tx_data[295:264] !== 32'h5) begin n_fail++; $display("FAIL single_nonce: got %h want 5", bus.tx_data[295:264]); end
    n_checks++;
    if (bus.tx_data[511:448] !== TAG) begin n_fail++; $display("FAIL single_tag: got %h want %h", bus.tx_data[511:448], TAG); end
    n_checks++;
    if (bus.tx_data !== fmt(share_hash(32'hcafe), 32'h5)) begin n_fail++; $display("FAIL single_msg: got %h", bus.tx_data); end
    drive_cycle('0, '0, 0, 1);
    n_checks++;
    if (obs_out.size() != 1 || count !== 3'd0) begin
      n_fail++; $display("FAIL single_pop: pops %0d count %0d want 1 and 0", obs_out.size(), count);
    end
  endtask

  task automatic test_non_share();
    drive_cycle({32'h0000_0001, 224'h0}, 32'h9, 1, 0);
    n_checks++;
    if (count !== 3'd0 || bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL non_share: count %0d valid %b want 0 0", count, bus.tx_valid);
    end
  endtask

  task automatic test_overflow();
    exp_out.delete(); obs_out.delete();
    for (int i = 1; i <= 6; i++) drive_cycle(share_hash(i), i, 1, 0);
    n_checks++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", count); end
    n_checks++;
    if (drop_count !== 16'd2 || drop_count !== 16'(m_drop)) begin
      n_fail++; $display("FAIL ovf_drop: got %0d want 2", drop_count);
    end
    n_checks++;
    if (bus.tx_data !== mq[0]) begin n_fail++; $display("FAIL ovf_hold: head %h", bus.tx_data[295:264]); end
    for (int i = 0; i < 5; i++) drive_cycle('0, '0, 0, 1);
    n_checks++;
    if (obs_out.size() != 4) begin
      n_fail++; $display("FAIL ovf_pops: got %0d want 4", obs_out.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (obs_out[i][295:264] !== 32'(i + 1)) begin
          n_fail++; $display("FAIL ovf_order: slot %0d got %0d want %0d", i, obs_out[i][295:264], i + 1);
        end
    end
  endtask

  task automatic test_full_push_pop();
    int d0;
    exp_out.delete(); obs_out.delete();
    for (int i = 10; i <= 13; i++) drive_cycle(share_hash(i), i, 1, 0);
    d0 = m_drop;
    drive_cycle(share_hash(14), 14, 1, 1);
    n_checks++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d want 4", count); end
    n_checks++;
    if (drop_count !== 16'(d0)) begin n_fail++; $display("FAIL fpp_drop: got %0d want %0d", drop_count, d0); end
    for (int i = 0; i < 4; i++) drive_cycle('0, '0, 0, 1);
    n_checks++;
    if (obs_out.size() != 5 || obs_out[4][295:264] !== 32'd14 || obs_out[1][295:264] !== 32'd11) begin
      n_fail++; $display("FAIL fpp_order: pops %0d last %0d want 5 and 14", obs_out.size(),
                         obs_out.size() > 0 ? obs_out[obs_out.size()-1][295:264] : 32'hx);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 20; i < 23; i++) drive_cycle(share_hash(i), i, 1, 0);
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (count !== 3'd0 || bus.tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: count %0d valid %b want 0 0", count, bus.tx_valid);
    end
    n_checks++;
    if (drop_count !== 16'd0) begin n_fail++; $display("FAIL async_rst_drop: got %0d want 0", drop_count); end
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    drive_cycle(share_hash(32'h77), 32'h77, 1, 0);
    n_checks++;
    if (bus.tx_valid !== 1'b1 || count !== 3'd1 || bus.tx_data[295:264] !== 32'h77) begin
      n_fail++; $display("FAIL after_rst: valid %b count %0d nonce %h want 1 1 77",
                         bus.tx_valid, count, bus.tx_data[295:264]);
    end
    drive_cycle('0, '0, 0, 1);
  endtask

  task automatic test_dup_nonce();
    for (int i = 0; i < 3; i++) drive_cycle(share_hash(32'h700 + i), 32'h7, 1, 0);
`ifdef RESULT_QUEUE_DUP_FILTER_EN
    n_checks++;
    if (count !== 3'd1 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL dup_filter: count %0d drop %0d want 1 0", count, drop_count);
    end
`else
    n_checks++;
    if (count !== 3'd3 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL dup_nofilter: count %0d drop %0d want 3 0", count, drop_count);
    end
`endif
    n_checks++;
    if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL dup_model: got %0d want %0d", count, mq.size()); end
    for (int i = 0; i < 4; i++) drive_cycle('0, '0, 0, 1);
  endtask

  task automatic test_random();
    logic [255:0] h;
    int errs;
    errs = 0;
    exp_out.delete(); obs_out.delete();
    for (int c = 0; c < 400; c++) begin
      h = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) h[255:224] = 32'h0;
      drive_cycle(h, 32'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      n_checks++;
      if (count !== 3'(mq.size()) || bus.tx_valid !== (mq.size() != 0)
          || drop_count !== 16'(m_drop) || (mq.size() != 0 && bus.tx_data !== mq[0])) begin
        n_fail++; errs++;
        if (errs < 5)
          $display("FAIL rand_cycle %0d: count %0d/%0d valid %b drop %0d/%0d", c, count, mq.size(),
                   bus.tx_valid, drop_count, m_drop);
      end
    end
    for (int i = 0; i < 6; i++) drive_cycle('0, '0, 0, 1);
    n_checks++;
    if (obs_out.size() != exp_out.size()) begin
      n_fail++; $display("FAIL rand_pops: got %0d want %0d", obs_out.size(), exp_out.size());
    end else begin
      for (int i = 0; i < exp_out.size(); i++)
        if (obs_out[i] !== exp_out[i]) begin
          n_fail++; $display("FAIL rand_data: pop %0d nonce %h want %h", i, obs_out[i][295:264], exp_out[i][295:264]);
          break;
        end
    end
  endtask

  initial begin
    test_reset();
    test_single_share();
    test_non_share();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_dup_nonce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
